// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle sequencer for the 16-bit ELEC326 CPU.
// Owns PC, IR and the carry flag. Runs the imem/dmem req/ack handshakes,
// consumes the decoder's one-hot strobes and emits regfile write controls.
module cpu_control_fsm #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_pi,
  input  logic                reset_pi,
  output logic                imem_req_po,
  input  logic                imem_ack_pi,
  input  logic [15:0]         imem_data_pi,
  output logic                dmem_req_po,
  output logic                dmem_we_po,
  input  logic                dmem_ack_pi,
  output logic [PC_WIDTH-1:0] pc_po,
  output logic [15:0]         ir_po,
  input  logic                dec_arith_2op_pi,
  input  logic                dec_arith_1op_pi,
  input  logic                dec_movi_lower_pi,
  input  logic                dec_movi_higher_pi,
  input  logic                dec_addi_pi,
  input  logic                dec_subi_pi,
  input  logic                dec_load_pi,
  input  logic                dec_store_pi,
  input  logic                dec_branch_eq_pi,
  input  logic                dec_branch_ge_pi,
  input  logic                dec_branch_le_pi,
  input  logic                dec_branch_carry_pi,
  input  logic                dec_jump_pi,
  input  logic                dec_stc_pi,
  input  logic                dec_stb_pi,
  input  logic                dec_halt_pi,
  input  logic                dec_rst_pi,
  input  logic [11:0]         dec_imm_pi,
  input  logic                alu_carry_pi,
  input  logic                cmp_eq_pi,
  input  logic                cmp_lt_pi,
  output logic                carry_po,
  output logic                reg_we_po,
  output logic [1:0]          wb_sel_po,
  output logic                halted_po
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [15:0]         r_ir, w_ir_nxt;
  logic                r_carry, w_carry_nxt;

  logic                w_alu, w_movi, w_mem, w_branch, w_taken, w_any_exec;
  logic [PC_WIDTH-1:0] w_br_off, w_jump_pc;

  assign w_alu      = dec_arith_2op_pi | dec_arith_1op_pi | dec_addi_pi | dec_subi_pi;
  assign w_movi     = dec_movi_lower_pi | dec_movi_higher_pi;
  assign w_mem      = dec_load_pi | dec_store_pi;
  assign w_branch   = dec_branch_eq_pi | dec_branch_ge_pi | dec_branch_le_pi | dec_branch_carry_pi;
  assign w_any_exec = w_alu | w_movi | w_mem | w_branch;

  // Branch condition from the comparator (and the carry flag for BC).
  assign w_taken = (dec_branch_eq_pi    & cmp_eq_pi)
                 | (dec_branch_ge_pi    & ~cmp_lt_pi)
                 | (dec_branch_le_pi    & (cmp_lt_pi | cmp_eq_pi))
                 | (dec_branch_carry_pi & r_carry);

  // 6-bit signed offset applied to the already-incremented PC.
  assign w_br_off = {{(PC_WIDTH-6){dec_imm_pi[5]}}, dec_imm_pi[5:0]};

  // Jump keeps the PC page above bit 12 and replaces the low 12 bits.
  generate
    if (PC_WIDTH > 12) begin : g_jmp_page
      assign w_jump_pc = {r_pc[PC_WIDTH-1:12], dec_imm_pi};
    end else begin : g_jmp_flat
      assign w_jump_pc = dec_imm_pi;
    end
  endgenerate

  // State, PC, IR and carry registers; reset wins over any pending handshake.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  // Next-state and architectural-state update per sequencer state.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_carry_nxt = r_carry;
    case (r_state)
      S_FETCH: begin
        if (imem_ack_pi) begin
          w_ir_nxt    = imem_data_pi;
          w_pc_nxt    = r_pc + PC_ONE;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_FETCH;
        if (dec_halt_pi) begin
          w_state_nxt = S_HALT;
        end else if (dec_rst_pi) begin
          w_pc_nxt    = RESET_PC;
          w_carry_nxt = 1'b0;
        end else if (dec_stc_pi) begin
          w_carry_nxt = 1'b1;
        end else if (dec_stb_pi) begin
          w_carry_nxt = 1'b0;
        end else if (dec_jump_pi) begin
          w_pc_nxt = w_jump_pc;
        end else if (w_any_exec) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_alu) begin
          w_carry_nxt = alu_carry_pi;
          w_state_nxt = S_WB;
        end else if (w_movi) begin
          w_state_nxt = S_WB;
        end else if (w_mem) begin
          w_state_nxt = S_MEM;
        end else begin
          if (w_taken) w_pc_nxt = r_pc + w_br_off;
          w_state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack_pi) w_state_nxt = dec_store_pi ? S_FETCH : S_WB;
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Handshake and writeback strobes are forced low while reset is held.
  always_comb begin
    imem_req_po = (r_state == S_FETCH) & ~reset_pi;
    dmem_req_po = (r_state == S_MEM)   & ~reset_pi;
    dmem_we_po  = dmem_req_po & dec_store_pi;
    reg_we_po   = (r_state == S_WB)    & ~reset_pi;
    halted_po   = (r_state == S_HALT)  & ~reset_pi;
    wb_sel_po   = 2'b00;
    if (r_state == S_WB) begin
      if (dec_load_pi)  wb_sel_po = 2'b01;
      else if (w_movi)  wb_sel_po = 2'b10;
    end
  end

  assign pc_po    = r_pc;
  assign ir_po    = r_ir;
  assign carry_po = r_carry;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: the bench plays decoder, memories
// and comparator, and checks PC/IR/carry and handshake timing by hand.
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [15:0] imem_data, pc, ir;
  logic        d_a2, d_a1, d_ml, d_mh, d_addi, d_subi, d_ld, d_st;
  logic        d_beq, d_bge, d_ble, d_bc, d_j, d_stc, d_stb, d_halt, d_rst;
  logic [11:0] d_imm;
  logic        alu_c, c_eq, c_lt;
  logic        carry, reg_we, halted;
  logic [1:0]  wb_sel;

  int errs = 0, checks = 0, cyc = 0;
  logic [15:0] epc, last_ir;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cpu_control_fsm dut (
    .clk_pi(clk), .reset_pi(rst),
    .imem_req_po(imem_req), .imem_ack_pi(imem_ack), .imem_data_pi(imem_data),
    .dmem_req_po(dmem_req), .dmem_we_po(dmem_we), .dmem_ack_pi(dmem_ack),
    .pc_po(pc), .ir_po(ir),
    .dec_arith_2op_pi(d_a2), .dec_arith_1op_pi(d_a1),
    .dec_movi_lower_pi(d_ml), .dec_movi_higher_pi(d_mh),
    .dec_addi_pi(d_addi), .dec_subi_pi(d_subi),
    .dec_load_pi(d_ld), .dec_store_pi(d_st),
    .dec_branch_eq_pi(d_beq), .dec_branch_ge_pi(d_bge),
    .dec_branch_le_pi(d_ble), .dec_branch_carry_pi(d_bc),
    .dec_jump_pi(d_j), .dec_stc_pi(d_stc), .dec_stb_pi(d_stb),
    .dec_halt_pi(d_halt), .dec_rst_pi(d_rst), .dec_imm_pi(d_imm),
    .alu_carry_pi(alu_c), .cmp_eq_pi(c_eq), .cmp_lt_pi(c_lt),
    .carry_po(carry), .reg_we_po(reg_we), .wb_sel_po(wb_sel), .halted_po(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dec();
    {d_a2, d_a1, d_ml, d_mh, d_addi, d_subi, d_ld, d_st} = '0;
    {d_beq, d_bge, d_ble, d_bc, d_j, d_stc, d_stb, d_halt, d_rst} = '0;
    d_imm = '0; alu_c = 0; c_eq = 0; c_lt = 0;
  endtask

  // Called in FETCH; returns in DECODE. wt = cycles of ack delay.
  task automatic fetch(input logic [15:0] instr, input int wt);
    int hi;
    hi = 0;
    for (int i = 0; i < wt; i++) begin
      imem_ack = 0; imem_data = 16'hDEAD; #1;
      if (imem_req) hi++;
      step();
      chk("fetch_wait_pc", pc, epc);
      chk("fetch_wait_ir", ir, last_ir);
    end
    imem_ack = 1; imem_data = instr; #1;
    if (imem_req) hi++;
    chk("fetch_req", imem_req, 1);
    step();
    imem_ack = 0; imem_data = 16'hDEAD; #1;
    epc = epc + 16'h1;
    last_ir = instr;
    chk("fetch_ir", ir, instr);
    chk("fetch_pc", pc, epc);
    chk("fetch_req_drop", imem_req, 0);
    if (wt > 0) chk("fetch_req_cycles", hi, wt + 1);
  endtask

  task automatic nop();
    clr_dec();
    fetch(16'h0000, 0);
    step();
    chk("nop_back", imem_req, 1);
  endtask

  task automatic do_jump(input logic [11:0] imm);
    logic [15:0] exp;
    clr_dec(); d_j = 1; d_imm = imm;
    fetch({4'hE, imm}, 0);
    exp = {epc[15:12], imm};
    step();
    chk("jump_pc", pc, exp);
    chk("jump_back", imem_req, 1);
    epc = exp;
    clr_dec();
  endtask

  // Branch kind: 0 eq, 1 ge, 2 le, 3 carry. exp = hand-computed next fetch address.
  task automatic br(input int kind, input logic [5:0] off, input logic eq, input logic lt,
                    input logic [15:0] exp);
    clr_dec();
    case (kind)
      0: d_beq = 1;
      1: d_bge = 1;
      2: d_ble = 1;
      default: d_bc = 1;
    endcase
    d_imm = {6'h0, off};
    fetch({4'h9, 6'h0, off}, 0);
    step();
    c_eq = eq; c_lt = lt; #1;
    chk("br_exec_we", reg_we, 0);
    step();
    chk("br_pc", pc, exp);
    chk("br_back", imem_req, 1);
    epc = exp;
    clr_dec();
  endtask

  initial begin
    int st, n;
    clr_dec();
    rst = 1; imem_ack = 0; imem_data = 16'h0; dmem_ack = 0;
    epc = 16'h0; last_ir = 16'h0;
    step(); step();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_carry", carry, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_halted", halted, 0);
    rst = 0; #1;
    chk("post_rst_req", imem_req, 1);

    // ADD r1,r0,r1: writeback on cycle 4, carry taken from ALU
    st = cyc;
    d_a2 = 1;
    fetch(16'h1208, 0);
    step();
    alu_c = 1; imem_ack = 1; imem_data = 16'hBEEF; #1;  // stray ack, no req
    chk("exec_we", reg_we, 0);
    chk("exec_carry_old", carry, 0);
    step();
    imem_ack = 0; alu_c = 0; #1;
    chk("add_ir_stray", ir, 16'h1208);
    chk("add_we", reg_we, 1);
    chk("add_sel", wb_sel, 2'b00);
    chk("add_pc", pc, 1);
    chk("add_carry", carry, 1);
    chk("add_cycle", cyc - st + 1, 4);
    step();
    chk("add_we_drop", reg_we, 0);
    chk("add_back", imem_req, 1);

    // Delayed instruction ack (3 cycles)
    clr_dec();
    fetch(16'h0000, 3);
    step();
    chk("nop_back2", imem_req, 1);

    // LOAD with dmem ack after 2 wait cycles: 7 cycles total
    st = cyc; n = 0;
    clr_dec(); d_ld = 1;
    fetch(16'h8123, 0);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dmem_ack = 1;
      #1;
      if (dmem_req) n++;
      chk("ld_we", dmem_we, 0);
      step();
    end
    dmem_ack = 0; #1;
    chk("ld_req_cycles", n, 3);
    chk("ld_reg_we", reg_we, 1);
    chk("ld_sel", wb_sel, 2'b01);
    chk("ld_cycle", cyc - st + 1, 7);
    step();

    // STORE, zero-wait ack: no writeback
    clr_dec(); d_st = 1;
    fetch(16'h9456, 0);
    step(); step();
    dmem_ack = 1; #1;
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    step();
    dmem_ack = 0; #1;
    chk("st_no_wb", reg_we, 0);
    chk("st_back", imem_req, 1);

    // MOVI writes the immediate path
    clr_dec(); d_ml = 1;
    fetch(16'h3012, 0);
    step(); step();
    chk("movi_we", reg_we, 1);
    chk("movi_sel", wb_sel, 2'b10);
    step();

    // BEQ at 0x0010 offset -2: taken -> 0x000F, not taken -> 0x0011
    do_jump(12'h010);
    br(0, 6'h3E, 1, 0, 16'h000F);
    do_jump(12'h010);
    br(0, 6'h3E, 0, 0, 16'h0011);
    br(1, 6'h02, 0, 1, 16'h0012);        // BGE, lt=1 -> not taken
    br(2, 6'h02, 0, 1, 16'h0015);        // BLE, lt=1 -> taken: 0x13+2

    // STC then BC +4 at pc 5 -> 0x000A; STB then BC -> 0x0006
    do_jump(12'h004);
    clr_dec(); d_stc = 1;
    fetch(16'hF001, 0); step();
    chk("stc_carry", carry, 1);
    br(3, 6'h04, 0, 0, 16'h000A);
    do_jump(12'h004);
    clr_dec(); d_stb = 1;
    fetch(16'hF002, 0); step();
    chk("stb_carry", carry, 0);
    br(3, 6'h04, 0, 0, 16'h0006);

    // RST command: pc back to reset value, carry cleared
    clr_dec(); d_stc = 1;
    fetch(16'hF001, 0); step();
    clr_dec(); d_rst = 1;
    fetch(16'hF003, 0); step();
    chk("rstcmd_pc", pc, 0);
    chk("rstcmd_carry", carry, 0);
    epc = 16'h0;

    // J imm=0xABC at pc 0x1234 -> 0x1ABC (reach page 1 via 0x0FFF)
    do_jump(12'hFFF);
    nop();
    do_jump(12'h234);
    do_jump(12'hABC);

    // HALT: sticky, no requests
    clr_dec(); d_halt = 1;
    fetch(16'hFFFF, 0);
    step();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req || dmem_req || !halted) n++;
      step();
    end
    chk("halt_quiet", n, 0);
    chk("halt_pc", pc, epc);
    rst = 1; #1;
    chk("halt_rst", halted, 0);
    step();
    rst = 0; #1;
    epc = 16'h0;
    chk("halt_exit_req", imem_req, 1);

    // Reset during a pending data access
    nop();
    clr_dec(); d_ld = 1;
    fetch(16'h8001, 0);
    step(); step(); step();
    chk("mem_wait_req", dmem_req, 1);
    rst = 1; #1;
    chk("mem_rst_req", dmem_req, 0);
    step();
    chk("mem_rst_pc", pc, 0);
    chk("mem_rst_req2", dmem_req, 0);
    rst = 0; clr_dec(); #1;
    chk("mem_rst_fetch", imem_req, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
